// File: rtl/decode_issue_queue.sv
// Decoding issue queue: up to two instructions pushed per cycle, up to two issued oldest-first with MIPS pairing rules.
// Latency: a pushed entry is first visible on out_* the cycle after the push; outputs are combinational from storage.
// Backpressure: in_ready drops when fewer than two entries are free; out_accept pops every slot flagged in out_valid.
module decode_issue_queue #(
    parameter int DEPTH = 8,
    parameter int DUAL  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [1:0]  in_valid,
    input  logic [31:0] in_instr0,
    input  logic [31:0] in_instr1,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    output logic [1:0]  out_valid,
    output logic [31:0] out_instr0,
    output logic [31:0] out_instr1,
    output logic [31:0] out_pc0,
    output logic [31:0] out_pc1,
    output logic [2:0]  out_cls0,
    output logic [2:0]  out_cls1,
    input  logic        out_accept
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] RDY_MAX = CW'(DEPTH - 2);

    localparam logic [2:0] CLS_ALU    = 3'd0;
    localparam logic [2:0] CLS_LOAD   = 3'd1;
    localparam logic [2:0] CLS_STORE  = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_HILOW  = 3'd4;
    localparam logic [2:0] CLS_HILOR  = 3'd5;
    localparam logic [2:0] CLS_PRIV   = 3'd6;
    localparam logic [2:0] CLS_RI     = 3'd7;

    function automatic logic [2:0] decode_cls(input logic [5:0] op, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [5:0] fn);
        decode_cls = CLS_RI;
        case (op)
            6'h00: case (fn)
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0a, 6'h0b, 6'h0f,
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                6'h30, 6'h31, 6'h32, 6'h33, 6'h34, 6'h36:      decode_cls = CLS_ALU;
                6'h08, 6'h09:                                  decode_cls = CLS_BRANCH;
                6'h0c, 6'h0d:                                  decode_cls = CLS_PRIV;
                6'h10, 6'h12:                                  decode_cls = CLS_HILOR;
                6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b:      decode_cls = CLS_HILOW;
                default:                                       decode_cls = CLS_RI;
            endcase
            6'h01: case (rt)
                5'h00, 5'h01, 5'h02, 5'h03, 5'h10, 5'h11, 5'h12, 5'h13: decode_cls = CLS_BRANCH;
                5'h08, 5'h09, 5'h0a, 5'h0b, 5'h0c, 5'h0e:               decode_cls = CLS_ALU;
                default:                                                decode_cls = CLS_RI;
            endcase
            6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
            6'h14, 6'h15, 6'h16, 6'h17:                        decode_cls = CLS_BRANCH;
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
            6'h33:                                             decode_cls = CLS_ALU;
            6'h10: begin
                // mfc0/mtc0, or CO-format eret/tlb*/wait
                if (rs == 5'h00 || rs == 5'h04)
                    decode_cls = CLS_PRIV;
                else if (rs[4] && (fn == 6'h01 || fn == 6'h02 || fn == 6'h06 ||
                                   fn == 6'h08 || fn == 6'h18 || fn == 6'h20))
                    decode_cls = CLS_PRIV;
            end
            6'h1c: case (fn)
                6'h00, 6'h01, 6'h04, 6'h05:                    decode_cls = CLS_HILOW;
                6'h02, 6'h20, 6'h21:                           decode_cls = CLS_ALU;
                default:                                       decode_cls = CLS_RI;
            endcase
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
            6'h30:                                             decode_cls = CLS_LOAD;
            6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e, 6'h38:          decode_cls = CLS_STORE;
            6'h2f:                                             decode_cls = CLS_PRIV;
            default:                                           decode_cls = CLS_RI;
        endcase
    endfunction

    // Architectural destination register; 0 means no destination.
    function automatic logic [4:0] dest_of(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [5:0] fn);
        dest_of = 5'd0;
        case (op)
            6'h00: case (fn)
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09, 6'h0a, 6'h0b, 6'h10, 6'h12,
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b:
                    dest_of = rd;
                default: dest_of = 5'd0;
            endcase
            6'h1c:  dest_of = (fn == 6'h02 || fn == 6'h20 || fn == 6'h21) ? rd : 5'd0;
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h30, 6'h38:
                    dest_of = rt;
            6'h10:  dest_of = (rs == 5'h00) ? rt : 5'd0;
            6'h03:  dest_of = 5'd31;
            6'h01:  dest_of = (rt[4:2] == 3'b100) ? 5'd31 : 5'd0;
            default: dest_of = 5'd0;
        endcase
    endfunction

    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic [2:0]    mem_cls   [DEPTH];
    logic [PW-1:0] head, tail, head1, tail1;
    logic [CW-1:0] count;
    logic [2:0]    in_cls0, in_cls1, cls0, cls1;
    logic [4:0]    dest0, rs1, rt1;
    logic          push_en, pop_en, pair_ok, v0;
    logic [1:0]    push_n, pop_n;

    assign head1 = head + PW'(1);
    assign tail1 = tail + PW'(1);

    assign in_cls0 = decode_cls(in_instr0[31:26], in_instr0[25:21], in_instr0[20:16], in_instr0[5:0]);
    assign in_cls1 = decode_cls(in_instr1[31:26], in_instr1[25:21], in_instr1[20:16], in_instr1[5:0]);

    assign out_instr0 = mem_instr[head];
    assign out_instr1 = mem_instr[head1];
    assign out_pc0    = mem_pc[head];
    assign out_pc1    = mem_pc[head1];
    assign cls0       = mem_cls[head];
    assign cls1       = mem_cls[head1];
    assign out_cls0   = cls0;
    assign out_cls1   = cls1;

    assign dest0 = dest_of(out_instr0[31:26], out_instr0[25:21], out_instr0[20:16],
                           out_instr0[15:11], out_instr0[5:0]);
    assign rs1   = out_instr1[25:21];
    assign rt1   = out_instr1[20:16];

    assign in_ready = (count <= RDY_MAX);

    always_comb begin
        pair_ok = 1'b0;
        // A branch waits for its delay slot so both always leave together.
        v0 = (count != '0) && !(cls0 == CLS_BRANCH && count == CW'(1));
        if (cls0 == CLS_BRANCH)
            pair_ok = (cls1 != CLS_BRANCH) && (cls1 != CLS_PRIV) && (cls1 != CLS_RI);
        else
            pair_ok = (cls0 != CLS_PRIV) && (cls0 != CLS_RI) &&
                      (cls1 != CLS_PRIV) && (cls1 != CLS_RI) && (cls1 != CLS_BRANCH) &&
                      !((cls0 == CLS_LOAD || cls0 == CLS_STORE) &&
                        (cls1 == CLS_LOAD || cls1 == CLS_STORE)) &&
                      !((cls0 == CLS_HILOW || cls0 == CLS_HILOR) &&
                        (cls1 == CLS_HILOW || cls1 == CLS_HILOR)) &&
                      !(dest0 != 5'd0 && (dest0 == rs1 || dest0 == rt1));
        out_valid[0] = v0;
        out_valid[1] = (DUAL != 0) && (count >= CW'(2)) && v0 && pair_ok;
    end

    assign push_en = in_valid[0] & in_ready & ~flush;
    assign pop_en  = out_accept & ~flush;
    assign push_n  = push_en ? (in_valid[1] ? 2'd2 : 2'd1) : 2'd0;
    assign pop_n   = pop_en ? ({1'b0, out_valid[0]} + {1'b0, out_valid[1]}) : 2'd0;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_n);
            tail  <= tail + PW'(push_n);
            count <= count + CW'(push_n) - CW'(pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_instr[tail] <= in_instr0;
            mem_pc[tail]    <= in_pc;
            mem_cls[tail]   <= in_cls0;
            if (in_valid[1]) begin
                mem_instr[tail1] <= in_instr1;
                mem_pc[tail1]    <= in_pc + 32'd4;
                mem_cls[tail1]   <= in_cls1;
            end
        end
    end
endmodule

// File: tb/tb_decode_issue_queue.sv
// Bench for decode_issue_queue: pairing vector table, directed multi-cycle sequences, random traffic vs queue model.
module tb_decode_issue_queue;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, flush, out_accept;
    logic [1:0]  in_valid;
    logic [31:0] in_instr0, in_instr1, in_pc;
    logic        in_ready, s_in_ready;
    logic [1:0]  out_valid, s_out_valid;
    logic [31:0] out_instr0, out_instr1, out_pc0, out_pc1;
    logic [31:0] s_out_instr0, s_out_instr1, s_out_pc0, s_out_pc1;
    logic [2:0]  out_cls0, out_cls1, s_out_cls0, s_out_cls1;

    always #5 clk = ~clk;

    decode_issue_queue #(.DEPTH(DEPTH), .DUAL(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_instr0(in_instr0), .in_instr1(in_instr1), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_instr0(out_instr0), .out_instr1(out_instr1),
        .out_pc0(out_pc0), .out_pc1(out_pc1), .out_cls0(out_cls0), .out_cls1(out_cls1),
        .out_accept(out_accept));

    decode_issue_queue #(.DEPTH(DEPTH), .DUAL(0)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_instr0(in_instr0), .in_instr1(in_instr1), .in_pc(in_pc), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_instr0(s_out_instr0), .out_instr1(s_out_instr1),
        .out_pc0(s_out_pc0), .out_pc1(s_out_pc1), .out_cls0(s_out_cls0), .out_cls1(s_out_cls1),
        .out_accept(out_accept));

    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] i0; logic [31:0] i1; logic [1:0] ov; logic [2:0] c0; logic [2:0] c1; } vec_t;

    ent_t        mq[$];
    vec_t        vt[20];
    logic [31:0] tf[22], tm[22];
    int          checks = 0, failures = 0;
    bit          mdl_on = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_cls(input logic [31:0] w);
        logic [5:0] op = w[31:26], fn = w[5:0];
        logic [4:0] rs = w[25:21], rt = w[20:16];
        ref_cls = 3'd7;
        if (op == 0) begin
            if (fn inside {0, 2, 3, 4, 6, 7, 'h0A, 'h0B, 'h0F, ['h20:'h27], 'h2A, 'h2B, ['h30:'h34], 'h36}) ref_cls = 3'd0;
            else if (fn inside {8, 9}) ref_cls = 3'd3;
            else if (fn inside {'h0C, 'h0D}) ref_cls = 3'd6;
            else if (fn inside {'h10, 'h12}) ref_cls = 3'd5;
            else if (fn inside {'h11, 'h13, ['h18:'h1B]}) ref_cls = 3'd4;
        end else if (op == 1) begin
            if (rt inside {[0:3], [16:19]}) ref_cls = 3'd3;
            else if (rt inside {[8:12], 14}) ref_cls = 3'd0;
        end else if (op inside {[2:7], [20:23]}) ref_cls = 3'd3;
        else if (op inside {[8:15], 'h33}) ref_cls = 3'd0;
        else if (op == 16) begin
            if (rs inside {0, 4} || (rs[4] && fn inside {1, 2, 6, 8, 'h18, 'h20})) ref_cls = 3'd6;
        end else if (op == 'h1C) begin
            if (fn inside {0, 1, 4, 5}) ref_cls = 3'd4;
            else if (fn inside {2, 'h20, 'h21}) ref_cls = 3'd0;
        end else if (op inside {['h20:'h26], 'h30}) ref_cls = 3'd1;
        else if (op inside {['h28:'h2B], 'h2E, 'h38}) ref_cls = 3'd2;
        else if (op == 'h2F) ref_cls = 3'd6;
    endfunction

    function automatic logic [4:0] ref_dest(input logic [31:0] w);
        logic [5:0] op = w[31:26], fn = w[5:0];
        if (op == 0 && fn inside {0, 2, 3, 4, 6, 7, 9, 'h0A, 'h0B, 'h10, 'h12, ['h20:'h27], 'h2A, 'h2B}) return w[15:11];
        if (op == 'h1C && fn inside {2, 'h20, 'h21}) return w[15:11];
        if (op inside {[8:15], ['h20:'h26], 'h30, 'h38}) return w[20:16];
        if (op == 16 && w[25:21] == 0) return w[20:16];
        if (op == 3 || (op == 1 && w[20:16] inside {[16:19]})) return 5'd31;
        return 5'd0;
    endfunction

    function automatic logic [1:0] ref_ov();
        logic [2:0] c0, c1;
        logic [4:0] d0;
        bit bad;
        if (mq.size() == 0) return 2'b00;
        c0 = ref_cls(mq[0].instr);
        if (mq.size() == 1) return (c0 == 3) ? 2'b00 : 2'b01;
        c1 = ref_cls(mq[1].instr);
        if (c0 == 3) return (c1 inside {3, 6, 7}) ? 2'b01 : 2'b11;
        d0 = ref_dest(mq[0].instr);
        bad = (c0 inside {6, 7}) || (c1 inside {3, 6, 7}) ||
              (c0 inside {1, 2} && c1 inside {1, 2}) || (c0 inside {4, 5} && c1 inside {4, 5}) ||
              (d0 != 0 && (d0 == mq[1].instr[25:21] || d0 == mq[1].instr[20:16]));
        return bad ? 2'b01 : 2'b11;
    endfunction

    task automatic tick();
        logic [1:0]  e_ov = ref_ov();
        int          n = mq.size();
        int          npop;
        logic        r_rst = rst, r_fl = flush, r_acc = out_accept;
        logic [1:0]  r_iv = in_valid;
        logic [31:0] r_i0 = in_instr0, r_i1 = in_instr1, r_pc = in_pc;
        if (mdl_on) begin
            chk("m_out_valid", 32'(out_valid), 32'(e_ov));
            chk("m_in_ready", 32'(in_ready), 32'(n <= DEPTH - 2));
            if (e_ov[0]) begin
                chk("m_instr0", out_instr0, mq[0].instr);
                chk("m_pc0", out_pc0, mq[0].pc);
                chk("m_cls0", 32'(out_cls0), 32'(ref_cls(mq[0].instr)));
            end
            if (e_ov[1]) begin
                chk("m_instr1", out_instr1, mq[1].instr);
                chk("m_pc1", out_pc1, mq[1].pc);
                chk("m_cls1", 32'(out_cls1), 32'(ref_cls(mq[1].instr)));
            end
            chk("single_never_dual", 32'(s_out_valid == 2'b11), 32'd0);
        end
        @(posedge clk);
        #1;
        if (!r_rst || r_fl) mq.delete();
        else begin
            npop = r_acc ? int'(e_ov[0]) + int'(e_ov[1]) : 0;
            for (int k = 0; k < npop; k++) mq.delete(0);
            if (r_iv[0] && n <= DEPTH - 2) begin
                mq.push_back(ent_t'{r_i0, r_pc});
                if (r_iv[1]) mq.push_back(ent_t'{r_i1, r_pc + 32'd4});
            end
        end
    endtask

    task automatic idle();
        rst = 1'b1; flush = 1'b0; out_accept = 1'b0; in_valid = 2'b00;
    endtask

    task automatic push(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        in_valid = v; in_instr0 = a; in_instr1 = b; in_pc = pc;
        tick();
        idle();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        idle();
    endtask

    function automatic logic [31:0] rnd_instr();
        int k = $urandom_range(0, 21);
        logic [31:0] r = {6'h0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 11'($urandom)};
        return (r & ~tm[k]) | tf[k];
    endfunction

    localparam logic [31:0] ADDU = 32'h00221821, LW = 32'h8CA40000, SUBU = 32'h00673023;
    localparam logic [31:0] BEQ = 32'h10220004, SYSC = 32'h0000000C, BAD = 32'hFC000000;
    localparam logic [31:0] DEPI = 32'h00631821;

    initial begin
        int pops;
        logic [31:0] last_pc;
        vt[0]  = '{ADDU, LW, 2'b11, 3'd0, 3'd1};
        vt[1]  = '{ADDU, SUBU, 2'b01, 3'd0, 3'd0};
        vt[2]  = '{LW, 32'hACE60000, 2'b01, 3'd1, 3'd2};
        vt[3]  = '{32'h00220018, 32'h00004010, 2'b01, 3'd4, 3'd5};
        vt[4]  = '{ADDU, BEQ, 2'b01, 3'd0, 3'd3};
        vt[5]  = '{BEQ, ADDU, 2'b11, 3'd3, 3'd0};
        vt[6]  = '{BEQ, SYSC, 2'b01, 3'd3, 3'd6};
        vt[7]  = '{SYSC, ADDU, 2'b01, 3'd6, 3'd0};
        vt[8]  = '{ADDU, BAD, 2'b01, 3'd0, 3'd7};
        vt[9]  = '{32'h0C000010, 32'h27E50001, 2'b11, 3'd3, 3'd0};
        vt[10] = '{32'h3C091234, 32'h8D2A0000, 2'b01, 3'd0, 3'd1};
        vt[11] = '{LW, 32'h00823821, 2'b01, 3'd1, 3'd0};
        vt[12] = '{32'h40086000, ADDU, 2'b01, 3'd6, 3'd0};
        vt[13] = '{32'h70221802, 32'h70850000, 2'b11, 3'd0, 3'd4};
        vt[14] = '{32'hE0620000, ADDU, 2'b01, 3'd2, 3'd0};
        vt[15] = '{32'h00220021, 32'h00073023, 2'b11, 3'd0, 3'd0};
        vt[16] = '{32'h04300008, 32'h00000000, 2'b11, 3'd3, 3'd0};
        vt[17] = '{32'hBC000000, ADDU, 2'b01, 3'd6, 3'd0};
        vt[18] = '{32'h00004010, 32'h01014821, 2'b01, 3'd5, 3'd0};
        vt[19] = '{32'h00200011, 32'h00001012, 2'b01, 3'd4, 3'd5};

        tf = '{32'h00000021, 32'h00000023, 32'h00000000, 32'h00000008, 32'h00000009, 32'h0000000C,
               32'h00000010, 32'h00000018, 32'h70000002, 32'h70000000, 32'h24000000, 32'h8C000000,
               32'hAC000000, 32'h10000000, 32'h0C000000, 32'h04110000, 32'h40000000, 32'h42000018,
               32'hFC000000, 32'hE0000000, 32'h3C000000, 32'h00000013};
        tm = '{32'hFC00003F, 32'hFC00003F, 32'hFC00003F, 32'hFC00003F, 32'hFC00003F, 32'hFC00003F,
               32'hFC00003F, 32'hFC00003F, 32'hFC00003F, 32'hFC00003F, 32'hFC000000, 32'hFC000000,
               32'hFC000000, 32'hFC000000, 32'hFC000000, 32'hFC1F0000, 32'hFFE00000, 32'hFFFFFFFF,
               32'hFC000000, 32'hFC000000, 32'hFC000000, 32'hFC00003F};

        // Reset with conflicting flush/push/pop in the same cycle
        idle();
        in_instr0 = ADDU; in_instr1 = LW; in_pc = 32'h0;
        rst = 1'b0; flush = 1'b1; in_valid = 2'b11; out_accept = 1'b1;
        tick();
        idle();
        mdl_on = 1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // First pair after reset, dual and single-issue instances
        push(2'b11, ADDU, LW, 32'h80);
        chk("first_ov", 32'(out_valid), 32'h3);
        chk("first_cls0", 32'(out_cls0), 32'd0);
        chk("first_cls1", 32'(out_cls1), 32'd1);
        chk("first_pc1", out_pc1, 32'h84);
        chk("single_first_ov", 32'(s_out_valid), 32'h1);

        for (int i = 0; i < 20; i++) begin
            do_flush();
            push(2'b11, vt[i].i0, vt[i].i1, 32'h1000 + 32'(i * 16));
            chk($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(vt[i].ov));
            chk($sformatf("vec%0d_cls0", i), 32'(out_cls0), 32'(vt[i].c0));
            chk($sformatf("vec%0d_cls1", i), 32'(out_cls1), 32'(vt[i].c1));
            chk($sformatf("vec%0d_pc1", i), out_pc1, 32'h1004 + 32'(i * 16));
        end

        // Dependent pair: second instruction issues alone after the first
        do_flush();
        push(2'b11, ADDU, SUBU, 32'h40);
        chk("dep_ov", 32'(out_valid), 32'h1);
        out_accept = 1'b1; tick(); idle();
        chk("dep_after_ov", 32'(out_valid), 32'h1);
        chk("dep_after_instr", out_instr0, SUBU);

        // Branch held until its delay slot arrives; accept while held pops nothing
        do_flush();
        push(2'b01, BEQ, 32'h0, 32'h100);
        chk("br_hold_ov", 32'(out_valid), 32'h0);
        out_accept = 1'b1;
        push(2'b01, 32'h0, 32'h0, 32'h104);
        chk("br_pair_ov", 32'(out_valid), 32'h3);
        chk("br_pair_cls0", 32'(out_cls0), 32'd3);
        chk("br_pair_pc0", out_pc0, 32'h100);
        chk("br_pair_pc1", out_pc1, 32'h104);
        out_accept = 1'b1; tick(); idle();
        chk("br_empty_ov", 32'(out_valid), 32'h0);

        // Fill to DEPTH-1, ignored push, single accept restores in_ready, drain
        do_flush();
        push(2'b11, DEPI, DEPI, 32'h200);
        push(2'b11, DEPI, DEPI, 32'h208);
        push(2'b11, DEPI, DEPI, 32'h210);
        push(2'b01, DEPI, DEPI, 32'h218);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        push(2'b11, ADDU, ADDU, 32'h900);
        chk("full_still_not_ready", 32'(in_ready), 32'd0);
        out_accept = 1'b1; tick(); idle();
        chk("full_ready_again", 32'(in_ready), 32'd1);
        chk("full_head_pc", out_pc0, 32'h204);
        pops = 0;
        last_pc = 32'h0;
        for (int k = 0; k < 20 && out_valid != 2'b00; k++) begin
            pops += int'(out_valid[0]) + int'(out_valid[1]);
            last_pc = out_pc0;
            out_accept = 1'b1; tick(); idle();
        end
        chk("drain_count", 32'(pops), 32'd6);
        chk("drain_last_pc", last_pc, 32'h218);
        chk("drain_empty", 32'(out_valid), 32'h0);

        // syscall issues alone; flush overrides same-cycle push and pop
        do_flush();
        push(2'b11, SYSC, ADDU, 32'h300);
        chk("sys_ov", 32'(out_valid), 32'h1);
        chk("sys_cls0", 32'(out_cls0), 32'd6);
        flush = 1'b1; out_accept = 1'b1;
        push(2'b11, ADDU, LW, 32'h380);
        chk("flush_ov", 32'(out_valid), 32'h0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        push(2'b11, ADDU, LW, 32'h400);
        chk("post_flush_ov", 32'(out_valid), 32'h3);
        chk("post_flush_pc0", out_pc0, 32'h400);

        // Reserved opcode issues alone
        do_flush();
        push(2'b11, BAD, ADDU, 32'h480);
        chk("ri_ov", 32'(out_valid), 32'h1);
        chk("ri_cls0", 32'(out_cls0), 32'd7);
        out_accept = 1'b1; tick(); idle();
        chk("ri_next_instr", out_instr0, ADDU);

        // Reset mid-stream with a branch held
        do_flush();
        push(2'b01, BEQ, 32'h0, 32'h500);
        chk("rst_hold_ov", 32'(out_valid), 32'h0);
        rst = 1'b0; flush = 1'b1; out_accept = 1'b1;
        in_valid = 2'b11; in_instr0 = ADDU; in_instr1 = LW;
        tick(); idle();
        chk("rst_mid_ov", 32'(out_valid), 32'h0);
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        push(2'b11, ADDU, LW, 32'h540);
        chk("rst_mid_after_pc0", out_pc0, 32'h540);

        // Random traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            out_accept = ($urandom_range(0, 9) < (i < 1500 ? 3 : 7));
            case ($urandom_range(0, 3))
                0:       in_valid = 2'b00;
                1:       in_valid = 2'b01;
                default: in_valid = 2'b11;
            endcase
            in_instr0 = rnd_instr();
            in_instr1 = rnd_instr();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_issue_queue.md
DECODE_ISSUE_QUEUE -- requirements
Module: decode_issue_queue

Interface
REQ-001 Parameters SHALL be:
- DEPTH, 8, queue entries (power of two, >=4).
- DUAL, 1, enables dual issue; 0 forces single issue.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  discard all queued entries.
- in_valid  in  2  push mask; in_valid[1] implies in_valid[0].
- in_instr0 / in_instr1  in  32 each  instructions at in_pc, in_pc+4.
- in_pc  in  32  PC of in_instr0.
- in_ready  out  1  queue can accept a 2-entry push this cycle.
- out_valid  out  2  issue mask; out_valid[1] implies out_valid[0].
- out_instr0 / out_instr1  out  32 each  issued instructions, oldest in slot 0.
- out_pc0 / out_pc1  out  32 each  their PCs.
- out_cls0 / out_cls1  out  3 each  decoded class (REQ-006).
- out_accept  in  1  downstream consumes every slot flagged in out_valid this cycle.

Function
REQ-003 Storage SHALL be a DEPTH-entry circular buffer holding {instr, pc, cls}, with head/tail pointers wrapping modulo DEPTH and a count of 0..DEPTH.
REQ-004 in_ready SHALL be 1 exactly when count <= DEPTH-2, evaluated on the current-cycle count; no same-cycle pop credit.
REQ-005 Push SHALL occur when in_valid[0] & in_ready & ~flush; it writes 1 or 2 entries at tail; entry 1 pc = in_pc+4; tail += popcount(in_valid).
REQ-006 cls SHALL be computed at push and stored:
- 0 ALU: R-type/special2 arithmetic, logic, shift, movz/movn, clz/clo, mul, traps, sync, pref.
- 1 LOAD: lb/lbu/lh/lhu/lw/lwl/lwr/ll.
- 2 STORE: sb/sh/sw/swl/swr/sc.
- 3 BRANCH: beq/bne/blez/bgtz and likely forms, all REGIMM branches, j/jal/jr/jalr.
- 4 HILOW: mult/multu/div/divu/mthi/mtlo/madd/maddu/msub/msubu.
- 5 HILOR: mfhi/mflo.
- 6 PRIV: COP0 (mfc0/mtc0/eret/tlb*/wait), syscall, break, cache.
- 7 RI: any other encoding.
REQ-007 out_* SHALL present head (slot 0) and head+1 (slot 1) combinationally from storage; a pushed entry is first visible the cycle after the push.
REQ-008 out_valid[0] SHALL be 1 when count>=1, except when head cls=3 and count==1 (branch holds until its delay slot is queued).
REQ-009 out_valid[1] SHALL be 1 only when DUAL=1, count>=2, out_valid[0]=1, and all of:
- neither cls is 6 or 7;
- slot1 cls != 3;
- not both cls in {1,2};
- not both cls in {4,5};
- slot0 destination (rd for R-type/special2 writers, rt for I-type ALU/loads/sc/mfc0, 31 for jal/bgezal/bltzal and likely forms; none otherwise; 0 = none) matches neither slot1 rs nor rt.
REQ-010 Rule exception: if slot0 cls=3, slot1 (its delay slot) SHALL be paired whenever count>=2 and slot1 cls not in {3,6,7}; a delay slot of cls 6/7 issues alone next.
REQ-011 Pop SHALL occur when out_accept & ~flush; head += popcount(out_valid); out_accept with out_valid=0 SHALL change nothing.
REQ-012 Simultaneous push and pop SHALL both apply: count_next = count + pushed - popped.
REQ-013 flush SHALL set head=tail=count=0 next cycle, overriding same-cycle push and pop.
REQ-014 Push while in_ready=0 SHALL be ignored with no state change; count SHALL never exceed DEPTH.

Reset
REQ-015 On a clk edge with rst=0: head=tail=count=0; next cycle out_valid=2'b00, in_ready=1; storage contents need not clear.
REQ-016 rst=0 SHALL override flush, push and pop in the same cycle, including mid-stream with a branch held per REQ-008.

Verification
REQ-017 Reset, then push {addu $3,$1,$2; lw $4,0($5)} at pc 0x80: next cycle out_valid=2'b11, cls0=0, cls1=1, pc1=0x84.
REQ-018 Queue {addu $3,$1,$2; subu $6,$3,$7}: out_valid=2'b01; after accept, subu issues alone in slot 0.
REQ-019 Push single beq at pc 0x100: out_valid=2'b00; push nop at 0x104: out_valid=2'b11, cls0=3; accept empties the queue.
REQ-020 DEPTH=8, fill to count=7 with no accept: in_ready=0, push ignored; one single-issue accept raises in_ready next cycle.
REQ-021 Queue {syscall; addu}: syscall issues alone with cls0=6; assert flush with in_valid=2'b11 the same cycle: next cycle out_valid=0, count=0.
REQ-022 Opcode 0x3F pushed: cls0=7, issued alone; DUAL=0 run of REQ-017: out_valid never 2'b11.
